// File: rtl/calculator_pkg.sv
// Shared calculator definitions: address/word sizes, memory state encoding
// and the default width of the memory access counters.
package calculator_pkg;

   localparam int ADDR_W        = 5;
   localparam int MEM_WORD_SIZE = 32;
   localparam int MEM_CNT_W     = 16;

   typedef enum logic {
      M_CLEAR = 1'b0,
      M_READY = 1'b1
   } mem_state_t;

endpackage

// File: rtl/calc_mem_array.sv
// Storage for calc_memory: DEPTH words, one synchronous write port and one
// combinational read port.
// Ports:
//   clk_i           clock
//   we              write enable
//   w_addr, w_data  write address / data
//   r_addr          read address
//   r_data          combinational read data
// The caller guarantees addresses are < DEPTH.
module calc_mem_array
   import calculator_pkg::*;
#(
   parameter int DEPTH = 2**ADDR_W
) (
   input  logic                     clk_i,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic [MEM_WORD_SIZE-1:0] w_data,
   input  logic [ADDR_W-1:0]        r_addr,
   output logic [MEM_WORD_SIZE-1:0] r_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [MEM_WORD_SIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[w_addr[IDX_W-1:0]] <= w_data;
      end
   end

   assign r_data = mem[r_addr[IDX_W-1:0]];

endmodule

// File: rtl/calc_memory.sv
// Word-addressed memory responder for the calculator controller.
// State table:
//   M_CLEAR | zeroing word clr_ptr each cycle, all strobes ignored
//   M_READY | serving reads, controller writes and preloads
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   read, r_addr, r_data         active-low read strobe, address, registered data
//   write, w_addr, w_data        active-low controller write strobe, address, data
//   load_en, load_addr, load_data  active-high preload port (wins over write)
//   busy                         clear in progress
//   addr_err, conflict_err       sticky error flags
//   rd_count, wr_count           saturating accepted-access counters
module calc_memory
   import calculator_pkg::*;
#(
   parameter int DEPTH          = 2**ADDR_W,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int CNT_W          = MEM_CNT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     read,
   input  logic [ADDR_W-1:0]        r_addr,
   output logic [MEM_WORD_SIZE-1:0] r_data,
   input  logic                     write,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic [MEM_WORD_SIZE-1:0] w_data,
   input  logic                     load_en,
   input  logic [ADDR_W-1:0]        load_addr,
   input  logic [MEM_WORD_SIZE-1:0] load_data,
   output logic                     busy,
   output logic                     addr_err,
   output logic                     conflict_err,
   output logic [CNT_W-1:0]         rd_count,
   output logic [CNT_W-1:0]         wr_count
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   mem_state_t               state, state_nxt;
   logic [ADDR_W-1:0]        clr_ptr, clr_ptr_nxt;
   logic                     arr_we, wr_take;
   logic [ADDR_W-1:0]        arr_waddr;
   logic [MEM_WORD_SIZE-1:0] arr_wdata, arr_rdata, rd_word;
   logic                     ready, rd_acc, wr_acc, ld_acc;
   logic                     r_ok, w_ok, l_ok, addr_bad;

   assign ready  = (state == M_READY);
   assign busy   = (state == M_CLEAR);
   assign rd_acc = ready & ~read;
   assign wr_acc = ready & ~write;
   assign ld_acc = ready & load_en;
   assign r_ok   = ({1'b0, r_addr}    < DEPTH_L);
   assign w_ok   = ({1'b0, w_addr}    < DEPTH_L);
   assign l_ok   = ({1'b0, load_addr} < DEPTH_L);
   assign addr_bad = (rd_acc & ~r_ok) | (wr_acc & ~w_ok) | (ld_acc & ~l_ok);

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      arr_we      = 1'b0;
      arr_waddr   = w_addr;
      arr_wdata   = w_data;
      wr_take     = 1'b0;
      case (state)
         M_CLEAR: begin
            arr_we    = 1'b1;
            arr_waddr = clr_ptr;
            arr_wdata = '0;
            if (clr_ptr == LAST) begin
               state_nxt = M_READY;
            end else begin
               clr_ptr_nxt = clr_ptr + 1'b1;
            end
         end
         M_READY: begin
            // A preload owns the write port even when its address is out of
            // range; the controller write is then simply dropped.
            if (ld_acc) begin
               arr_we    = l_ok;
               arr_waddr = load_addr;
               arr_wdata = load_data;
            end else if (wr_acc && w_ok) begin
               arr_we  = 1'b1;
               wr_take = 1'b1;
            end
         end
         default: state_nxt = M_READY;
      endcase
   end

   // Write-first: a read hitting the word being written sees the new data.
   assign rd_word = (arr_we && (arr_waddr == r_addr)) ? arr_wdata : arr_rdata;

   calc_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i  (clk_i),
      .we     (arr_we & ~rst_i),
      .w_addr (arr_waddr),
      .w_data (arr_wdata),
      .r_addr (r_addr),
      .r_data (arr_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= CLEAR_ON_RESET ? M_CLEAR : M_READY;
         clr_ptr      <= '0;
         r_data       <= '0;
         addr_err     <= 1'b0;
         conflict_err <= 1'b0;
         rd_count     <= '0;
         wr_count     <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
         if (rd_acc) begin
            r_data <= r_ok ? rd_word : '0;
         end
         if (rd_acc && r_ok && (rd_count != CNT_MAX)) begin
            rd_count <= rd_count + 1'b1;
         end
         if (wr_take && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + 1'b1;
         end
         if (addr_bad) begin
            addr_err <= 1'b1;
         end
         if (ld_acc && wr_acc) begin
            conflict_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_calc_memory.sv
// Self-checking bench for calc_memory: DEPTH=16 main instance with clear on
// reset, plus a CNT_W=4 instance without clear for counter saturation.
module tb_calc_memory;
   import calculator_pkg::*;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                     rst_i, read, write, load_en;
   logic [ADDR_W-1:0]        r_addr, w_addr, load_addr;
   logic [MEM_WORD_SIZE-1:0] w_data, load_data, r_data;
   logic                     busy, addr_err, conflict_err;
   logic [15:0]              rd_count, wr_count;

   logic                     rst2, read2, write2, load2;
   logic [ADDR_W-1:0]        r_addr2, w_addr2, load_addr2;
   logic [MEM_WORD_SIZE-1:0] w_data2, load_data2, r_data2;
   logic                     busy2, addr_err2, conflict_err2;
   logic [3:0]               rd_count2, wr_count2;

   calc_memory #(.DEPTH(16), .CLEAR_ON_RESET(1'b1), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .read(read), .r_addr(r_addr), .r_data(r_data),
      .write(write), .w_addr(w_addr), .w_data(w_data),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy), .addr_err(addr_err), .conflict_err(conflict_err),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   calc_memory #(.DEPTH(16), .CLEAR_ON_RESET(1'b0), .CNT_W(4)) dut2 (
      .clk_i(clk_i), .rst_i(rst2), .read(read2), .r_addr(r_addr2), .r_data(r_data2),
      .write(write2), .w_addr(w_addr2), .w_data(w_data2),
      .load_en(load2), .load_addr(load_addr2), .load_data(load_data2),
      .busy(busy2), .addr_err(addr_err2), .conflict_err(conflict_err2),
      .rd_count(rd_count2), .wr_count(wr_count2)
   );

   int checks = 0;
   int errors = 0;

   // Reference model of the ready-state behaviour of the main instance.
   logic [MEM_WORD_SIZE-1:0] mdl_mem [16];
   logic [MEM_WORD_SIZE-1:0] exp_r;
   logic [15:0]              exp_rd, exp_wr;
   logic                     exp_aerr, exp_cerr;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      read = 1'b1; write = 1'b1; load_en = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
      exp_r = '0; exp_rd = '0; exp_wr = '0; exp_aerr = 1'b0; exp_cerr = 1'b0;
   endtask

   // Apply the current inputs to the model (as one clock edge), then clock.
   task automatic step();
      if (load_en) begin
         if (load_addr < 16) mdl_mem[load_addr] = load_data;
         else exp_aerr = 1'b1;
         if (!write) begin
            exp_cerr = 1'b1;
            if (w_addr >= 16) exp_aerr = 1'b1;
         end
      end else if (!write) begin
         if (w_addr < 16) begin
            mdl_mem[w_addr] = w_data;
            if (exp_wr != 16'hFFFF) exp_wr++;
         end else exp_aerr = 1'b1;
      end
      if (!read) begin
         if (r_addr < 16) begin
            exp_r = mdl_mem[r_addr];
            if (exp_rd != 16'hFFFF) exp_rd++;
         end else begin
            exp_r = '0;
            exp_aerr = 1'b1;
         end
      end
      cyc();
   endtask

   task automatic count_clear(input string name);
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         read = 1'b0; r_addr = ADDR_W'($urandom_range(0, 31));
         write = 1'b0; w_addr = ADDR_W'($urandom_range(0, 31)); w_data = $urandom;
         load_en = 1'b1; load_addr = ADDR_W'($urandom_range(0, 31)); load_data = $urandom;
         cyc();
         n++;
      end
      idle();
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL %s: busy lasted %0d cycles, expected 16", name, n);
      end
   endtask

   task automatic check_state(input string name);
      checks++;
      if (r_data !== exp_r || rd_count !== exp_rd || wr_count !== exp_wr ||
          addr_err !== exp_aerr || conflict_err !== exp_cerr || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s: r_data=%h rd=%0d wr=%0d aerr=%b cerr=%b busy=%b, expected r_data=%h rd=%0d wr=%0d aerr=%b cerr=%b busy=0",
                  name, r_data, rd_count, wr_count, addr_err, conflict_err, busy,
                  exp_r, exp_rd, exp_wr, exp_aerr, exp_cerr);
      end
   endtask

   task automatic test_reset();
      idle(); rst_i = 1'b1;
      cyc();
      checks++;
      if (r_data !== '0 || busy !== 1'b1 || addr_err !== 1'b0 || conflict_err !== 1'b0 ||
          rd_count !== '0 || wr_count !== '0) begin
         errors++;
         $display("FAIL reset_values: r_data=%h busy=%b aerr=%b cerr=%b rd=%0d wr=%0d, expected 0/1/0/0/0/0",
                  r_data, busy, addr_err, conflict_err, rd_count, wr_count);
      end
      rst_i = 1'b0;
      model_reset();
      count_clear("clear_duration");
      check_state("after_clear");
      read = 1'b0; r_addr = 5;
      step(); idle();
      check_state("read_cleared_word");
   endtask

   task automatic test_preload_read();
      load_en = 1'b1; load_addr = 3; load_data = 32'hA5A5_1234;
      step(); idle();
      read = 1'b0; r_addr = 3;
      step(); idle();
      check_state("preload_read");
      checks++;
      if (r_data !== 32'hA5A5_1234) begin
         errors++;
         $display("FAIL preload_data: got %h expected a5a51234", r_data);
      end
   endtask

   task automatic test_write_first();
      write = 1'b0; w_addr = 7; w_data = 32'hDEAD_BEEF;
      read = 1'b0; r_addr = 7;
      step(); idle();
      check_state("write_first");
      checks++;
      if (r_data !== 32'hDEAD_BEEF || wr_count !== 16'd1) begin
         errors++;
         $display("FAIL write_first_data: got %h wr=%0d expected deadbeef wr=1", r_data, wr_count);
      end
      cyc();
      check_state("read_holds");
   endtask

   task automatic test_out_of_range();
      read = 1'b0; r_addr = 20;
      step(); idle();
      check_state("oor_read");
      read = 1'b0; r_addr = 3;
      step(); idle();
      check_state("oor_sticky");
      write = 1'b0; w_addr = 25; w_data = 32'h1234_5678;
      step(); idle();
      check_state("oor_write_dropped");
   endtask

   task automatic test_conflict();
      load_en = 1'b1; load_addr = 2; load_data = 32'h1;
      write = 1'b0; w_addr = 9; w_data = 32'h2;
      step(); idle();
      check_state("conflict_flag");
      read = 1'b0; r_addr = 2;
      step(); idle();
      check_state("conflict_preload_kept");
      read = 1'b0; r_addr = 9;
      step(); idle();
      check_state("conflict_write_dropped");
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         read      = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
         r_addr    = ADDR_W'($urandom_range(0, 15));
         write     = ($urandom_range(0, 1) != 0) ? 1'b0 : 1'b1;
         w_addr    = ADDR_W'($urandom_range(0, 15));
         w_data    = $urandom;
         load_en   = ($urandom_range(0, 4) == 0);
         load_addr = ADDR_W'($urandom_range(0, 15));
         load_data = $urandom;
         if ($urandom_range(0, 3) == 0) r_addr = w_addr;
         step();
         check_state("random");
      end
      idle();
   endtask

   task automatic test_reset_mid_clear();
      rst_i = 1'b1; cyc(); rst_i = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
      // Access presented together with reset must be discarded.
      rst_i = 1'b1; read = 1'b0; r_addr = 1; write = 1'b0; w_addr = 4; w_data = 32'hFFFF_0000;
      cyc();
      rst_i = 1'b0; idle();
      model_reset();
      count_clear("restart_clear");
      check_state("after_restart");
      read = 1'b0; r_addr = 4;
      step(); idle();
      check_state("restart_zeroed");
   endtask

   task automatic test_saturation();
      read2 = 1'b1; write2 = 1'b1; load2 = 1'b0; rst2 = 1'b1;
      r_addr2 = 0; w_addr2 = 0; load_addr2 = 0; w_data2 = '0; load_data2 = '0;
      cyc();
      rst2 = 1'b0;
      checks++;
      if (busy2 !== 1'b0 || rd_count2 !== 4'd0 || wr_count2 !== 4'd0) begin
         errors++;
         $display("FAIL noclear_reset: busy=%b rd=%0d wr=%0d expected 0/0/0", busy2, rd_count2, wr_count2);
      end
      load2 = 1'b1; load_addr2 = 1; load_data2 = 32'h0BAD_F00D;
      cyc(); load2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         read2 = 1'b0; r_addr2 = 1;
         write2 = 1'b0; w_addr2 = 6; w_data2 = i;
         cyc();
         if (i == 13) begin
            checks++;
            if (rd_count2 !== 4'd14) begin
               errors++;
               $display("FAIL count_below_sat: got %0d expected 14", rd_count2);
            end
         end
      end
      read2 = 1'b1; write2 = 1'b1;
      checks++;
      if (rd_count2 !== 4'd15 || wr_count2 !== 4'd15 || r_data2 !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL saturation: rd=%0d wr=%0d data=%h expected 15/15/0badf00d", rd_count2, wr_count2, r_data2);
      end
   endtask

   initial begin
      rst_i = 1'b1; idle();
      r_addr = 0; w_addr = 0; load_addr = 0; w_data = '0; load_data = '0;
      rst2 = 1'b1; read2 = 1'b1; write2 = 1'b1; load2 = 1'b0;
      r_addr2 = 0; w_addr2 = 0; load_addr2 = 0; w_data2 = '0; load_data2 = '0;
      test_reset();
      test_preload_read();
      test_write_first();
      test_out_of_range();
      test_conflict();
      test_random();
      test_reset_mid_clear();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
